// File: rtl/gate_truth_checker_pkg.sv
// Shared definitions for the gate truth-table checker: FSM encoding and
// reference truth tables for common two-input gates.
package gate_truth_checker_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit i is the gate output for input combination i.
  localparam logic [3:0] TtOr2  = 4'b1110;
  localparam logic [3:0] TtAnd2 = 4'b1000;
  localparam logic [3:0] TtXor2 = 4'b0110;

  // Counter width able to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gate_truth_checker_dwell_timer.sv
// Dwell counter: counts cycles within one held input combination and flags
// the final cycle, where the gate output gets sampled.
module gate_truth_checker_dwell_timer
  import gate_truth_checker_pkg::*;
#(
  parameter int unsigned DWELL = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned CntW = cnt_width(DWELL);
  localparam logic [CntW-1:0] CntMax = CntW'(DWELL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == CntMax);

  // Next count: clear wins, otherwise wrap after the last dwell cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Clocked exerciser for a small combinational gate: walks every input
// combination in ascending order, holds each for DWELL cycles, samples the
// gate output in the last dwell cycle and scores it against EXPECTED.
module gate_truth_checker
  import gate_truth_checker_pkg::*;
#(
  parameter int unsigned             N_IN     = 2,
  parameter int unsigned             DWELL    = 10,
  parameter logic [(2**N_IN)-1:0]    EXPECTED = TtOr2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            y,
  output logic            busy,
  output logic            sample_valid,
  output logic [N_IN-1:0] sample_idx,
  output logic            sample_y,
  output logic            sample_ok,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_idx
);

  localparam int unsigned     NComb   = 2**N_IN;
  localparam logic [N_IN-1:0] LastIdx = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ErrMax  = (N_IN + 1)'(NComb);

  state_e          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fail_q, fail_d;
  logic            sv_q, sv_d;
  logic [N_IN-1:0] sidx_q, sidx_d;
  logic            sy_q, sy_d;
  logic            sok_q, sok_d;

  logic last;
  logic sample_now;
  logic y_ok;

  gate_truth_checker_dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != StRun),
    .en   (state_q == StRun),
    .last (last)
  );

  assign sample_now = (state_q == StRun) && last;
  assign y_ok       = (y == EXPECTED[stim_q]);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (last && (stim_q == LastIdx)) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Datapath next values: run setup on start, scoring on the sample cycle.
  always_comb begin
    stim_d = stim_q;
    err_d  = err_q;
    fail_d = fail_q;
    sv_d   = 1'b0;
    sidx_d = sidx_q;
    sy_d   = sy_q;
    sok_d  = sok_q;
    if ((state_q != StRun) && start) begin
      stim_d = '0;
      err_d  = '0;
      fail_d = '0;
    end else if (sample_now) begin
      sv_d   = 1'b1;
      sidx_d = stim_q;
      sy_d   = y;
      sok_d  = y_ok;
      if (!y_ok) begin
        if (err_q != ErrMax) err_d = err_q + 1'b1;
        if (err_q == '0) fail_d = stim_q;
      end
      // The last combination stays on stim while DONE.
      if (stim_q != LastIdx) stim_d = stim_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim_q <= '0;
      err_q  <= '0;
      fail_q <= '0;
      sv_q   <= 1'b0;
      sidx_q <= '0;
      sy_q   <= 1'b0;
      sok_q  <= 1'b0;
    end else begin
      stim_q <= stim_d;
      err_q  <= err_d;
      fail_q <= fail_d;
      sv_q   <= sv_d;
      sidx_q <= sidx_d;
      sy_q   <= sy_d;
      sok_q  <= sok_d;
    end
  end

  // Outputs decoded from state plus the registered datapath.
  always_comb begin
    busy         = (state_q == StRun);
    done         = (state_q == StDone);
    pass         = (state_q == StDone) && (err_q == '0);
    stim         = stim_q;
    sample_valid = sv_q;
    sample_idx   = sidx_q;
    sample_y     = sy_q;
    sample_ok    = sok_q;
    err_count    = err_q;
    fail_idx     = fail_q;
  end

endmodule
